// File: rtl/dalu_pipe_pkg.sv
// Shared types and defaults for the pipelined affine dual ALU.
// Beat control word carried alongside each operand pair.
package affine;

  localparam int unsigned DEFAULT_W     = 8;
  localparam int unsigned DEFAULT_FRAC  = 7;
  localparam int unsigned DEFAULT_LANES = 2;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_MAC  = 2'd1,
    MODE_ADD  = 2'd2,
    MODE_RSVD = 2'd3
  } tMODE;

  typedef struct packed {
    tMODE mode;
    logic frac;
    logic sat;
    logic clr;
  } tDOP;

endpackage

// File: rtl/dalu_pipe_if.sv
// Operand/result handshake bundle for dalu_pipe; slave is the ALU side.
interface dalu_pipe_if #(
  parameter int unsigned W     = affine::DEFAULT_W,
  parameter int unsigned LANES = affine::DEFAULT_LANES
) ();
  import affine::*;

  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] a;
  logic [LANES*W-1:0] b;
  tDOP                op;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] r;
  logic [LANES-1:0]   ovf;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, r, ovf
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, r, ovf
  );

endinterface

// File: rtl/dalu_pipe_lane.sv
// Per-lane post-multiply datapath: scale, add/accumulate, narrow with
// optional saturation, and next accumulator value. Purely combinational.
module dalu_lane
  import affine::*;
#(
  parameter int unsigned W    = DEFAULT_W,
  parameter int unsigned FRAC = DEFAULT_FRAC
) (
  input  logic signed [2*W-1:0] p,
  input  logic signed [2*W-1:0] p_nbr,
  input  logic                  add_nbr,
  input  tDOP                   op,
  input  logic signed [W-1:0]   acc,
  output logic [W-1:0]          r_c,
  output logic                  ovf_c,
  output logic signed [W-1:0]   acc_nxt_c
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = 2 * W + 1;

  localparam logic signed [SW-1:0] S_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
  localparam logic [W-1:0]         R_MAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]         R_MIN = {1'b1, {(W - 1){1'b0}}};

  logic signed [PW-1:0] p_sh;
  logic signed [PW-1:0] pn_sh;
  logic signed [SW-1:0] m;
  logic signed [SW-1:0] m_nbr;
  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] s;
  logic                 hi;
  logic                 lo;
  logic [W-1:0]         narrow;

  // Arithmetic shift on the full-width product truncates toward -inf.
  always_comb begin
    p_sh    = p >>> FRAC;
    pn_sh   = p_nbr >>> FRAC;
    m       = op.frac ? SW'(p_sh) : SW'(p);
    m_nbr   = op.frac ? SW'(pn_sh) : SW'(p_nbr);
    acc_ext = SW'(acc);
  end

  always_comb begin
    s = m;
    unique case (op.mode)
      MODE_MAC: if (!op.clr) s = m + acc_ext;
      MODE_ADD: if (add_nbr) s = m + m_nbr;
      default:  s = m;
    endcase
  end

  always_comb begin
    hi     = s > S_MAX;
    lo     = s < S_MIN;
    ovf_c  = hi | lo;
    narrow = s[W-1:0];
    if (op.sat && hi) narrow = R_MAX;
    if (op.sat && lo) narrow = R_MIN;
    r_c    = narrow;
  end

  // Non-MAC beats only touch the accumulator when clearing it.
  always_comb begin
    acc_nxt_c = acc;
    if (op.mode == MODE_MAC) acc_nxt_c = $signed(narrow);
    else if (op.clr)         acc_nxt_c = '0;
  end

endmodule

// File: rtl/dalu_pipe.sv
// Two-stage pipelined multi-lane fixed-point ALU (MUL / MAC / pairwise ADD)
// with a single global stall enable driven by the output handshake.
module dalu_pipe
  import affine::*;
#(
  parameter int unsigned W     = DEFAULT_W,
  parameter int unsigned FRAC  = DEFAULT_FRAC,
  parameter int unsigned LANES = DEFAULT_LANES
) (
  input  logic        clk,
  input  logic        rst,
  dalu_pipe_if.slave  io
);

  localparam int unsigned PW = 2 * W;

  logic                 advance;
  logic                 s1_valid;
  tDOP                  s1_op;
  logic signed [PW-1:0] s1_p [LANES];

  logic signed [W-1:0]  acc [LANES];
  logic [W-1:0]         lane_r [LANES];
  logic                 lane_ovf [LANES];
  logic signed [W-1:0]  lane_acc [LANES];
  logic signed [PW-1:0] prod [LANES];

  logic                 out_valid_q;
  logic [LANES*W-1:0]   r_q;
  logic [LANES-1:0]     ovf_q;

  assign advance      = !out_valid_q | io.out_ready;
  assign io.in_ready  = advance;
  assign io.out_valid = out_valid_q;
  assign io.r         = r_q;
  assign io.ovf       = ovf_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned NBR = (i % 2 == 0) ? i + 1 : i;

    logic signed [W-1:0] a_l;
    logic signed [W-1:0] b_l;
    logic                add_nbr;

    assign a_l     = io.a[i*W +: W];
    assign b_l     = io.b[i*W +: W];
    assign prod[i] = PW'(a_l) * PW'(b_l);
    assign add_nbr = (i % 2 == 0);

    dalu_lane #(.W(W), .FRAC(FRAC)) u_lane (
      .p        (s1_p[i]),
      .p_nbr    (s1_p[NBR]),
      .add_nbr  (add_nbr),
      .op       (s1_op),
      .acc      (acc[i]),
      .r_c      (lane_r[i]),
      .ovf_c    (lane_ovf[i]),
      .acc_nxt_c(lane_acc[i])
    );
  end

  // Stage 1: capture full-width products and the beat control.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      for (int i = 0; i < LANES; i++) s1_p[i] <= '0;
    end else if (advance) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_op <= io.op;
        for (int i = 0; i < LANES; i++) s1_p[i] <= prod[i];
      end
    end
  end

  // Stage 2: register results; accumulators move only with a real beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (advance) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          r_q[i*W +: W] <= lane_r[i];
          ovf_q[i]      <= lane_ovf[i];
          acc[i]        <= lane_acc[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_dalu_pipe.sv
// Directed bench for dalu_pipe (W=8, FRAC=7, LANES=2) with hand-computed
// expectations; outputs are collected by a handshake monitor.
module tb_dalu_pipe;
  import affine::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [17:0] rq[$];

  always #5 clk = ~clk;

  dalu_pipe_if #(.W(8), .LANES(2)) io ();

  dalu_pipe #(.W(8), .FRAC(7), .LANES(2)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tDOP mkop(input tMODE md, input logic fr, input logic sat, input logic clr);
    tDOP o;
    o.mode = md;
    o.frac = fr;
    o.sat  = sat;
    o.clr  = clr;
    return o;
  endfunction

  // Present a beat at the falling edge and hold it until accepted.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input tDOP o);
    int n = 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a = av;
    io.b = bv;
    io.op = o;
    #1;
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (rq.size() < n && k < 100) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (rq.size() < n) chk("out_timeout", 32'(rq.size()), 32'(n));
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] er, input logic [1:0] eo);
    logic [17:0] x;
    if (rq.size() == 0) begin
      chk({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      x = rq.pop_front();
      chk({tag, "_r"}, 32'(x[15:0]), 32'(er));
      chk({tag, "_ovf"}, 32'(x[17:16]), 32'(eo));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && io.out_valid && io.out_ready) rq.push_back({io.ovf, io.r});
    end
  end

  initial begin
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.op = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_r", 32'(io.r), 32'd0);
    chk("rst_ovf", 32'(io.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);

    // Fractional MUL and latency.
    send(16'h0040, 16'h0040, mkop(MODE_MUL, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    io.in_valid = 1'b0;
    #1;
    chk("lat_s1", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("lat_out", 32'(io.out_valid), 32'd1);
    wait_out(1);
    pop_chk("frac_mul", 16'h0020, 2'b00);

    // Negative product truncates toward -inf; -1.0*-1.0 saturates.
    send(16'h80FF, 16'h8001, mkop(MODE_MUL, 1'b1, 1'b1, 1'b0));
    idle();
    wait_out(1);
    pop_chk("frac_edge", 16'h7FFF, 2'b10);

    // Integer MUL, saturating then wrapping.
    send(16'h6403, 16'h02FC, mkop(MODE_MUL, 1'b0, 1'b1, 1'b0));
    send(16'h6403, 16'h02FC, mkop(MODE_MUL, 1'b0, 1'b0, 1'b0));
    idle();
    wait_out(2);
    pop_chk("mul_sat", 16'h7FF4, 2'b10);
    pop_chk("mul_wrap", 16'hC8F4, 2'b10);

    // Back-to-back MAC with a saturating fourth beat.
    send(16'h000A, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b1));
    send(16'h0014, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
    send(16'h001E, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
    send(16'h007F, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b1, 1'b0));
    idle();
    wait_out(4);
    pop_chk("mac0", 16'h000A, 2'b00);
    pop_chk("mac1", 16'h001E, 2'b00);
    pop_chk("mac2", 16'h003C, 2'b00);
    pop_chk("mac3", 16'h007F, 2'b01);

    // Pairwise ADD; clr on ADD zeroes accumulators without touching result.
    send(16'h0705, 16'h0102, mkop(MODE_ADD, 1'b0, 1'b0, 1'b0));
    send(16'h0705, 16'h0102, mkop(MODE_ADD, 1'b0, 1'b0, 1'b1));
    send(16'h0002, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
    idle();
    wait_out(3);
    pop_chk("add", 16'h0711, 2'b00);
    pop_chk("add_clr", 16'h0711, 2'b00);
    pop_chk("mac_after_clr", 16'h0002, 2'b00);

    // Backpressure mid-stream.
    fork
      begin
        send(16'h0001, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b1));
        send(16'h0002, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
        send(16'h0003, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
        send(16'h0004, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        io.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          #1;
          chk("stall_in_ready", 32'(io.in_ready), 32'd0);
        end
        @(negedge clk);
        io.out_ready = 1'b1;
      end
    join
    wait_out(4);
    pop_chk("bp0", 16'h0001, 2'b00);
    pop_chk("bp1", 16'h0003, 2'b00);
    pop_chk("bp2", 16'h0006, 2'b00);
    pop_chk("bp3", 16'h000A, 2'b00);
    repeat (3) @(negedge clk);
    chk("bp_extra", 32'(rq.size()), 32'd0);

    // Reset with beats in flight, then MAC without clr sees acc=0.
    send(16'h0001, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
    send(16'h0001, 16'h0001, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    io.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_r", 32'(io.r), 32'd0);
    chk("mid_rst_ready", 32'(io.in_ready), 32'd1);
    rq.delete();
    send(16'h0005, 16'h0003, mkop(MODE_MAC, 1'b0, 1'b0, 1'b0));
    idle();
    wait_out(1);
    pop_chk("post_rst_mac", 16'h000F, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
